captura_entradas: RTL and testbench
===================================

# captura_entradas

Input-conditioning stage directly upstream of the access-control combinational core. It synchronises and debounces the two users' raw switches and push-buttons, and captures a request (HH, B) on each button press. It presents that request to the core for a fixed display window, then returns the core inputs to a neutral value. The two user channels are independent and identical, so the core's arbitration sees only clean, stable requests.

## Interface
Parameters:
- DEB_CYCLES, 500000: consecutive stable cycles required before a debounced key changes (10 ms at 50 MHz); must be ≥ 2.
- HOLD_CYCLES, 250000000: cycles a captured request stays presented (5 s at 50 MHz); must be ≥ 1.

Ports:
- CLK  in  1  single system clock; all state changes on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- SW0  in  4  user 0 raw switches (asynchronous).
- SW1  in  4  user 1 raw switches (asynchronous).
- KEY0  in  2  user 0 raw push-buttons; active-low, bouncy, asynchronous.
- KEY1  in  2  user 1 raw push-buttons; active-low, bouncy, asynchronous.
- HH0  out  4  captured user 0 code to the core.
- HH1  out  4  captured user 1 code to the core.
- B0  out  2  captured user 0 key pattern to the core; active-low.
- B1  out  2  captured user 1 key pattern to the core; active-low.
- VALID0  out  1  high while the user 0 request is presented.
- VALID1  out  1  high while the user 1 request is presented.

## Operation
- Synchronisers:
  - Every raw input passes a 2-flop synchroniser.
  - After reset, switch flops hold 0 and key flops hold 1 (released).
- Debounce, per key bit:
  - A counter counts cycles on which the synchronised value differs from the debounced value.
  - The counter clears whenever the two values agree.
  - When the count reaches DEB_CYCLES-1 and the values still differ, the debounced value takes the synchronised value and the counter clears.
  - Any disagreement lasting fewer than DEB_CYCLES cycles never reaches the debounced value.
  - The debounced value resets to 1.
- Press event:
  - A press is the debounced key pair of a user going from 2'b11 to any other value in one cycle.
  - A 1-cycle internal strobe marks the press.
- Per-user FSM:
  - IDLE:
    - Outputs are neutral: HH=4'b0000, B=2'b11, VALID=0.
    - On a press strobe: capture the synchronised SW into HH and the debounced key pair into B, load the hold counter with HOLD_CYCLES-1, and go to ACTIVE.
  - ACTIVE:
    - VALID=1; HH and B hold the captured values unchanged.
    - The hold counter decrements every cycle.
    - When the counter is 0, go to WAIT_REL.
    - Press strobes and SW changes are ignored.
  - WAIT_REL:
    - Outputs are neutral.
    - Leave for IDLE on the first cycle the debounced keys equal 2'b11.
    - If the keys are already 2'b11 on entry, the state lasts exactly one cycle.
    - A held key can therefore never retrigger a capture.
- Boundary conditions:
  - Both users pressing in the same cycle: both capture independently; no priority exists at this stage.
  - A press during WAIT_REL is ignored. The key must release and press again to capture.
  - Both key bits changing in the same debounced cycle count as one press, and B captures the combined pattern (e.g. 2'b00).
  - RST asserted mid-operation forces both FSMs to IDLE, all counters to 0, and outputs to neutral on the next edge, regardless of state.

## Timing
- All outputs are registered; no combinational path runs from input to output.
- Reset values: HH0=HH1=4'b0000, B0=B1=2'b11, VALID0=VALID1=0.
- Latency: a raw key that goes low before edge t and stays low produces the debounced change after edge t+1+DEB_CYCLES. HH, B and VALID update after edge t+2+DEB_CYCLES.
- HH captures the SW value that was synchronised at the press cycle, i.e. the raw SW two edges earlier.
- VALID is high for exactly HOLD_CYCLES consecutive cycles per capture.
- HH and B hold the captured values for those same HOLD_CYCLES cycles, then return to neutral in the same cycle that VALID falls.

## Structure
- Shared package captura_pkg holds:
  - the state constants IDLE=2'd0, ACTIVE=2'd1, WAIT_REL=2'd2;
  - HH_NEUTRAL=4'b0000 and B_NEUTRAL=2'b11.
- Sub-module debounce_botao: synchroniser plus debouncer for one key bit, parameterised by DEB_CYCLES. It is instantiated four times.
- The top level holds the switch synchronisers, the two per-user FSMs and the two hold counters. The hold counter width is $clog2(HOLD_CYCLES+1).

## Test plan
All scenarios use DEB_CYCLES=4 and HOLD_CYCLES=8.
- Reset: hold RST for 3 cycles with random inputs → HH0=HH1=0000, B0=B1=11, VALID0=VALID1=0.
- Clean press: SW0=4'b1011, KEY0 goes 11→10 and is held → VALID0 rises exactly 6 cycles later with HH0=1011 and B0=10, stays high 8 cycles, then HH0=0000 and B0=11.
- Bounce: KEY0 toggles low/high every 2 cycles for 20 cycles, then returns to 11 → VALID0 never rises.
- Held key: KEY1=01 held for 40 cycles with SW1=0110 → exactly one 8-cycle VALID1 pulse with HH1=0110. A second pulse occurs only after release followed by a new press.
- Simultaneous users and mid-window changes: both keys pressed in the same cycle, then SW0 changes during ACTIVE → VALID0 and VALID1 rise in the same cycle, and HH0 keeps the value captured at the press.
- Reset mid-window: assert RST for 1 cycle during ACTIVE → the next cycle shows neutral outputs. The following press captures normally.

Source files
------------

// File: rtl/captura_pkg.sv
// Constants shared by the input-capture stage: per-user FSM states and the
// neutral values presented to the access-control core.
package captura_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACTIVE   = 2'd1;
    localparam logic [1:0] WAIT_REL = 2'd2;

    localparam logic [3:0] HH_NEUTRAL = 4'b0000;
    localparam logic [1:0] B_NEUTRAL  = 2'b11;

endpackage

// File: rtl/debounce_botao.sv
// Two-flop synchroniser followed by a stability-count debouncer for one
// active-low push-button bit; the released level (1) is the reset value.
module debounce_botao #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_deb
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             key_meta;
    logic             key_sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            key_deb  <= 1'b1;
            cnt      <= '0;
        end else begin
            key_meta <= key_raw;
            key_sync <= key_meta;
            // Only an unbroken run of DEB_CYCLES disagreeing cycles moves the output.
            if (key_sync == key_deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                key_deb <= key_sync;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/captura_entradas.sv
// Conditions both users' switches and buttons, captures (HH, B) on a press and
// presents it to the core for HOLD_CYCLES cycles before returning to neutral.
module captura_entradas
    import captura_pkg::*;
#(
    parameter int DEB_CYCLES  = 500000,
    parameter int HOLD_CYCLES = 250000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] SW0,
    input  logic [3:0] SW1,
    input  logic [1:0] KEY0,
    input  logic [1:0] KEY1,
    output logic [3:0] HH0,
    output logic [3:0] HH1,
    output logic [1:0] B0,
    output logic [1:0] B1,
    output logic       VALID0,
    output logic       VALID1
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0][1:0]        key_raw;
    logic [1:0][1:0]        key_deb;
    logic [1:0][1:0]        key_prev;
    logic [1:0]             press;
    logic [1:0][3:0]        sw_meta;
    logic [1:0][3:0]        sw_sync;
    logic [1:0][1:0]        state;
    logic [1:0][HOLD_W-1:0] hold;
    logic [1:0][3:0]        hh_q;
    logic [1:0][1:0]        b_q;
    logic [1:0]             valid_q;

    assign key_raw[0] = KEY0;
    assign key_raw[1] = KEY1;

    for (genvar u = 0; u < 2; u++) begin : g_user
        for (genvar b = 0; b < 2; b++) begin : g_bit
            debounce_botao #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_debounce (
                .clk    (CLK),
                .rst    (RST),
                .key_raw(key_raw[u][b]),
                .key_deb(key_deb[u][b])
            );
        end
    end

    // A press is the debounced pair leaving the fully-released pattern.
    always_comb begin
        press = '0;
        for (int u = 0; u < 2; u++) begin
            press[u] = (key_prev[u] == B_NEUTRAL) && (key_deb[u] != B_NEUTRAL);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_prev <= {2{B_NEUTRAL}};
            state    <= {2{IDLE}};
            hold     <= '0;
            hh_q     <= {2{HH_NEUTRAL}};
            b_q      <= {2{B_NEUTRAL}};
            valid_q  <= '0;
        end else begin
            sw_meta  <= {SW1, SW0};
            sw_sync  <= sw_meta;
            key_prev <= key_deb;
            for (int u = 0; u < 2; u++) begin
                case (state[u])
                    IDLE: begin
                        if (press[u]) begin
                            hh_q[u]    <= sw_sync[u];
                            b_q[u]     <= key_deb[u];
                            hold[u]    <= HOLD_LOAD;
                            valid_q[u] <= 1'b1;
                            state[u]   <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (hold[u] == '0) begin
                            hh_q[u]    <= HH_NEUTRAL;
                            b_q[u]     <= B_NEUTRAL;
                            valid_q[u] <= 1'b0;
                            state[u]   <= WAIT_REL;
                        end else begin
                            hold[u] <= hold[u] - HOLD_W'(1);
                        end
                    end
                    WAIT_REL: begin
                        // Holding the key keeps us here, so it cannot retrigger.
                        if (key_deb[u] == B_NEUTRAL) begin
                            state[u] <= IDLE;
                        end
                    end
                    default: begin
                        hh_q[u]    <= HH_NEUTRAL;
                        b_q[u]     <= B_NEUTRAL;
                        valid_q[u] <= 1'b0;
                        hold[u]    <= '0;
                        state[u]   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign HH0    = hh_q[0];
    assign HH1    = hh_q[1];
    assign B0     = b_q[0];
    assign B1     = b_q[1];
    assign VALID0 = valid_q[0];
    assign VALID1 = valid_q[1];

endmodule

// File: tb/tb_captura_entradas.sv
// Directed bench for captura_entradas with a cycle-level behavioural model and
// hand-computed checks of latency, pulse width and captured values.
module tb_captura_entradas;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw0, sw1;
    logic [1:0] key0, key1;
    logic [3:0] hh0, hh1;
    logic [1:0] b0, b1;
    logic       valid0, valid1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    captura_entradas #(
        .DEB_CYCLES (DEB),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .SW0   (sw0),
        .SW1   (sw1),
        .KEY0  (key0),
        .KEY1  (key1),
        .HH0   (hh0),
        .HH1   (hh1),
        .B0    (b0),
        .B1    (b1),
        .VALID0(valid0),
        .VALID1(valid1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: raw samples ride a two-deep pipe, a key bit flips after
    // DEB consecutive disagreeing samples, and a capture lasts HOLD cycles.
    logic [1:0][3:0] m_s1, m_s2;
    logic [1:0][1:0] m_k1, m_k2, m_deb, m_prev;
    int              m_run [2][2];
    int              m_rem [2];
    bit              m_wait [2];
    logic [1:0][3:0] m_hh;
    logic [1:0][1:0] m_b;
    logic [1:0]      m_v;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0;
            m_k1 = '1; m_k2 = '1; m_deb = '1; m_prev = '1;
            m_hh = '0; m_b = '1; m_v = '0;
            for (int u = 0; u < 2; u++) begin
                m_rem[u] = 0;
                m_wait[u] = 1'b0;
                for (int b = 0; b < 2; b++) m_run[u][b] = 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (m_rem[u] > 0) begin
                    m_rem[u]--;
                    if (m_rem[u] == 0) begin
                        m_hh[u] = 4'b0000; m_b[u] = 2'b11; m_v[u] = 1'b0;
                        m_wait[u] = 1'b1;
                    end
                end else if (m_wait[u]) begin
                    if (m_deb[u] == 2'b11) m_wait[u] = 1'b0;
                end else if (m_prev[u] == 2'b11 && m_deb[u] != 2'b11) begin
                    m_hh[u] = m_s2[u]; m_b[u] = m_deb[u]; m_v[u] = 1'b1;
                    m_rem[u] = HOLD;
                end
            end
            m_prev = m_deb;
            for (int u = 0; u < 2; u++) begin
                for (int b = 0; b < 2; b++) begin
                    if (m_k2[u][b] != m_deb[u][b]) begin
                        m_run[u][b]++;
                        if (m_run[u][b] == DEB) begin
                            m_deb[u][b] = m_k2[u][b];
                            m_run[u][b] = 0;
                        end
                    end else begin
                        m_run[u][b] = 0;
                    end
                end
            end
            m_k2 = m_k1; m_k1 = {key1, key0};
            m_s2 = m_s1; m_s1 = {sw1, sw0};
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            chk("cycle_model", {18'd0, hh0, b0, valid0, hh1, b1, valid1},
                {18'd0, m_hh[0], m_b[0], m_v[0], m_hh[1], m_b[1], m_v[1]});
    end

    int rise0 = 0, rise1 = 0;
    logic pv0 = 1'b0, pv1 = 1'b0;
    always @(negedge clk) begin
        if (valid0 === 1'b1 && pv0 !== 1'b1) rise0++;
        if (valid1 === 1'b1 && pv1 !== 1'b1) rise1++;
        pv0 = valid0;
        pv1 = valid1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int u, input int max, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (((u == 0) ? valid0 : valid1) !== 1'b1 && k < max);
    endtask

    task automatic pulse_width(input int u, output int w);
        w = 0;
        do begin
            w++;
            @(negedge clk);
        end while (((u == 0) ? valid0 : valid1) === 1'b1 && w < 50);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, w, r, cnt_hi;
        bit seen;
        logic [3:0] cap_hh;
        logic [1:0] cap_b;

        rst = 1'b1;
        repeat (3) begin
            sw0 = 4'($urandom); sw1 = 4'($urandom);
            key0 = 2'($urandom); key1 = 2'($urandom);
            @(negedge clk);
        end
        chk("reset_outputs", {hh0, b0, valid0, hh1, b1, valid1}, {4'b0000, 2'b11, 1'b0, 4'b0000, 2'b11, 1'b0});
        sw0 = '0; sw1 = '0; key0 = 2'b11; key1 = 2'b11;
        rst = 1'b0;
        chk_en = 1'b1;
        tick(4);

        // Clean press on user 0
        sw0 = 4'b1011;
        tick(2);
        key0 = 2'b10;
        wait_valid(0, 30, k);
        chk("press_latency", k, 7);
        chk("press_hh0", hh0, 4'b1011);
        chk("press_b0", b0, 2'b10);
        pulse_width(0, w);
        chk("press_width", w, HOLD);
        chk("after_hh0", hh0, 4'b0000);
        chk("after_b0", b0, 2'b11);
        key0 = 2'b11;
        tick(10);

        // Bounce shorter than the debounce window
        r = rise0;
        for (int i = 0; i < 10; i++) begin
            key0 = (i % 2 == 0) ? 2'b10 : 2'b11;
            tick(2);
        end
        key0 = 2'b11;
        tick(10);
        chk("bounce_no_valid", rise0 - r, 0);

        // Held key on user 1
        sw1 = 4'b0110;
        tick(2);
        r = rise1;
        key1 = 2'b01;
        seen = 1'b0; cnt_hi = 0; cap_hh = '0; cap_b = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid1 === 1'b1) begin
                cnt_hi++;
                if (!seen) begin
                    seen = 1'b1; cap_hh = hh1; cap_b = b1;
                end
            end
        end
        chk("held_one_pulse", rise1 - r, 1);
        chk("held_width", cnt_hi, HOLD);
        chk("held_hh1", cap_hh, 4'b0110);
        chk("held_b1", cap_b, 2'b01);
        key1 = 2'b11;
        tick(10);
        chk("release_no_pulse", rise1 - r, 1);
        sw1 = 4'b1110;
        tick(2);
        key1 = 2'b10;
        wait_valid(1, 30, k);
        chk("second_press_valid", valid1, 1'b1);
        chk("second_press_hh1", hh1, 4'b1110);
        tick(12);
        key1 = 2'b11;
        tick(10);

        // Simultaneous presses, SW0 changes mid-window
        sw0 = 4'b0101; sw1 = 4'b1001;
        tick(2);
        key0 = 2'b00; key1 = 2'b10;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (valid0 !== 1'b1 && valid1 !== 1'b1 && k < 30);
        chk("simul_rise", {valid0, valid1}, 2'b11);
        chk("simul_b0_both", b0, 2'b00);
        sw0 = 4'b1111;
        tick(4);
        chk("simul_hold_hh0", hh0, 4'b0101);
        chk("simul_hh1", hh1, 4'b1001);
        tick(10);
        key0 = 2'b11; key1 = 2'b11;
        tick(10);

        // Reset inside the active window
        sw0 = 4'b0011;
        tick(2);
        key0 = 2'b01;
        wait_valid(0, 30, k);
        chk("pre_rst_valid", valid0, 1'b1);
        tick(2);
        rst = 1'b1;
        key0 = 2'b11;
        tick(1);
        rst = 1'b0;
        chk("rst_mid_neutral", {hh0, b0, valid0}, {4'b0000, 2'b11, 1'b0});
        tick(10);
        sw0 = 4'b1100;
        tick(2);
        key0 = 2'b10;
        wait_valid(0, 30, k);
        chk("post_rst_latency", k, 7);
        chk("post_rst_hh0", hh0, 4'b1100);
        tick(12);
        key0 = 2'b11;
        tick(10);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
